mem_ctrl: RTL
=============

Name: mem_ctrl

Overview:
- Memory-side responder for the instruction-fetch line-fill interface and the load/store buffer data interface.
- Serializes requests onto the single byte-wide RAM/IO port.
- Assembles 64-byte instruction lines (512 bit, little-endian) and 1/2/4-byte load data.
- Sits between the fetch/LSB units and the top-level RAM/IO bus; exactly one transaction is in flight at a time.

Parameters:
- LINE_BYTES, 64, bytes per instruction-cache line; fixes if_data width at 512 bits.
- IO_SEL_HI, 17, high bit of the 2-bit IO-space selector. Address is IO when addr[IO_SEL_HI:IO_SEL_HI-1]==2'b11.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-low reset: rst=0 resets immediately.
- rdy  in  1  global enable; 0 freezes the block.
- io_buffer_full  in  1  IO sink cannot accept a write this cycle.
- mem_din  in  8  RAM read byte for the address presented in the previous cycle.
- mem_dout  out  8  write byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write this cycle.
- if_en  in  1  line-fill request level; held until if_done.
- if_pc  in  32  line address; bits [5:0] ignored, treated as 0.
- if_done  out  1  one-cycle pulse; if_data valid.
- if_data  out  512  filled line; byte k at [8k+7:8k].
- lsb_en  in  1  data request level; held until lsb_done.
- lsb_wr  in  1  1 = store, 0 = load.
- lsb_addr  in  32  byte address.
- lsb_len  in  2  0=1B, 1=2B, 2=4B; 3 treated as 4B.
- lsb_wdata  in  32  store data; byte k at [8k+7:8k].
- lsb_done  out  1  one-cycle pulse.
- lsb_rdata  out  32  load data, zero-extended above the loaded bytes.

Behaviour:
- Reset (rst=0, asynchronous, any state):
  - state=IDLE; if_done=0, lsb_done=0, mem_wr=0, mem_a=0, mem_dout=0, if_data=0, lsb_rdata=0, counter=0.
  - An in-flight transaction is abandoned; the requester re-issues it.
- States: IDLE, READ, WRITE, DONE. The count N is latched at acceptance: 64 for a line fill, otherwise from lsb_len.
- IDLE:
  - lsb_en=1 wins over if_en=1 when both are high in the same cycle; the loser stays pending.
  - On acceptance, latch base address, client, and N. Next state is READ (if fill or load) or WRITE (store), with j=0.
- READ, cycles j=0..N:
  - mem_a=base+j (for j=N the value is don't-care); mem_wr=0.
  - At the edge ending cycle j≥1, capture mem_din as byte j-1.
  - At the edge ending j=N, go to DONE.
  - Latency: request seen in IDLE cycle T0 → done pulse in cycle T0+N+2. A line fill gives done at T0+66; a word load gives done at T0+6.
- WRITE, cycles j=0..N-1:
  - mem_a=base+j, mem_dout=byte j, mem_wr=1.
  - IO stall: if io_buffer_full=1 and base is in IO space, mem_wr=0 and j does not advance.
  - After the last write, go to DONE. An unstalled word store gives done at T0+5.
- DONE (one cycle):
  - Pulse if_done or lsb_done for the served client; all requests are ignored this cycle. Next state is IDLE.
  - The requester drops its enable at the same edge, so the request is never re-accepted.
  - if_data and lsb_rdata hold until that client's next read completes.
- rdy=0:
  - State, counter, and captured data are frozen; mem_wr forced 0; done outputs hold their value.
  - In READ with j≥1, mem_a=base+j-1, so mem_din on the resume cycle still carries byte j-1.
- mem_a, mem_wr, and mem_dout are combinational from state and counter. Address arithmetic is 32-bit and wraps modulo 2^32.
- Requester contract: address, length, and data are stable while en is high. Deasserting en mid-transaction does not abort the transaction.

Test Plan:
- Line fill: RAM[0x1040+k]=k, if_en=1, if_pc=0x1044 in cycle 0 → mem_a steps 0x1040..0x107F. if_done is high in cycle 66 only, with if_data byte k=k.
- Word load: RAM[0x200..0x203]=EF,BE,AD,DE, lsb_len=2 → lsb_done at cycle 6, lsb_rdata=0xDEADBEEF. Then a 1-byte load at 0x201 → lsb_rdata=0x000000BE.
- Half store: lsb_wr=1, addr=0x30000 (IO), lsb_wdata=0x1234, io_buffer_full=1 for 3 cycles → mem_wr held 0 for those 3 cycles. Then 0x34 goes to 0x30000 and 0x12 to 0x30001; lsb_done follows the second write by 1 cycle.
- Simultaneous if_en and lsb_en (word load) in cycle 0 → load done at cycle 6, fill accepted at cycle 7, if_done at cycle 73.
- rdy=0 for cycles 10..14 during a fill → if_done delayed by 5 cycles to cycle 71, and if_data is identical to the unstalled run.
- rst=0 pulsed at cycle 30 of a fill → all outputs zero immediately and no done pulse. The re-issued fill completes 66 cycles after its first IDLE acceptance cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// Byte-serial memory responder for instruction line fills and LSB loads/stores.
// One transaction in flight; line and load data are assembled little-endian.
module mem_ctrl #(
  parameter int LINE_BYTES = 64,
  parameter int IO_SEL_HI  = 17
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    io_buffer_full,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [31:0]             mem_a,
  output logic                    mem_wr,
  input  logic                    if_en,
  input  logic [31:0]             if_pc,
  output logic                    if_done,
  output logic [LINE_BYTES*8-1:0] if_data,
  input  logic                    lsb_en,
  input  logic                    lsb_wr,
  input  logic [31:0]             lsb_addr,
  input  logic [1:0]              lsb_len,
  input  logic [31:0]             lsb_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata
);

  localparam int LW = LINE_BYTES * 8;
  localparam int CW = $clog2(LINE_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] n_q, n_d;
  logic [31:0]   base_q, base_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          lsb_q, lsb_d;
  logic [LW-1:0] buf_q, buf_d;
  logic [LW-1:0] line_q, line_d;
  logic [31:0]   rdata_q, rdata_d;

  logic [CW-1:0] idx;
  logic [31:0]   lmask;
  logic          stall;

  assign if_done   = (state_q == DONE) && !lsb_q;
  assign lsb_done  = (state_q == DONE) && lsb_q;
  assign if_data   = line_q;
  assign lsb_rdata = rdata_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    base_d   = base_q;
    wdata_d  = wdata_q;
    lsb_d    = lsb_q;
    buf_d    = buf_q;
    line_d   = line_q;
    rdata_d  = rdata_q;
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    idx      = cnt_q - CW'(1);
    stall    = (&base_q[IO_SEL_HI -: 2]) && io_buffer_full;
    unique case (n_q)
      CW'(1):  lmask = 32'h0000_00ff;
      CW'(2):  lmask = 32'h0000_ffff;
      default: lmask = 32'hffff_ffff;
    endcase
    unique case (state_q)
      IDLE: begin
        if (rdy && lsb_en) begin
          lsb_d   = 1'b1;
          base_d  = lsb_addr;
          wdata_d = lsb_wdata;
          cnt_d   = '0;
          unique case (lsb_len)
            2'd0:    n_d = CW'(1);
            2'd1:    n_d = CW'(2);
            default: n_d = CW'(4);
          endcase
          state_d = lsb_wr ? WRITE : READ;
        end else if (rdy && if_en) begin
          lsb_d   = 1'b0;
          base_d  = if_pc & ~32'(LINE_BYTES - 1);
          cnt_d   = '0;
          n_d     = CW'(LINE_BYTES);
          state_d = READ;
        end
      end
      READ: begin
        // while frozen, keep the previous address so mem_din stays valid
        if (!rdy && cnt_q != '0) mem_a = base_q + 32'(idx);
        else                     mem_a = base_q + 32'(cnt_q);
        if (rdy) begin
          if (cnt_q != '0)
            buf_d[{idx[CW-2:0], 3'b000} +: 8] = mem_din;
          if (cnt_q == n_q) begin
            state_d = DONE;
            if (lsb_q) rdata_d = buf_d[31:0] & lmask;
            else       line_d  = buf_d;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      WRITE: begin
        mem_a    = base_q + 32'(cnt_q);
        mem_dout = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy && !stall) begin
          mem_wr = 1'b1;
          if (cnt_q == n_q - CW'(1)) state_d = DONE;
          else                       cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (rdy) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      lsb_q   <= 1'b0;
      buf_q   <= '0;
      line_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      lsb_q   <= lsb_d;
      buf_q   <= buf_d;
      line_q  <= line_d;
      rdata_q <= rdata_d;
    end
  end

endmodule
